// File: rtl/bk_pkg.sv
// Shared types and constants for the Brent-Kung multi-word adder sequencer.
package bk_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bk_seq_state_t;

endpackage

// File: rtl/bk_multiword_add_seq_if.sv
// Operand request / result handshake bundle for the multi-word add sequencer.
// master: the operand source and result sink; slave: the sequencer itself.
interface bk_multiword_add_seq_if
  import bk_pkg::*;
#(
  parameter int NWORDS = 4
) ();

  localparam int W = WORD_W * NWORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, op_a, op_b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, op_a, op_b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/brent_kung_adder.sv
// 32-bit combinational Brent-Kung prefix adder. The word carry-in is folded
// into bit 0's generate so the prefix tree yields the carry out of every bit.
module brent_kung_adder
  import bk_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              ci,
  output logic [WORD_W-1:0] s,
  output logic              co
);

  localparam int LOG_W = $clog2(WORD_W);

  logic [WORD_W-1:0] g_s;
  logic [WORD_W-1:0] p_s;
  logic [WORD_W-1:0] carry_s;

  // Returns the carry out of each bit position: up-sweep builds power-of-two
  // spans, down-sweep fills in the remaining prefixes.
  function automatic logic [WORD_W-1:0] bk_carries(
    input logic [WORD_W-1:0] g_in,
    input logic [WORD_W-1:0] p_in,
    input logic              c0
  );
    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;
    g    = g_in;
    p    = p_in;
    g[0] = g_in[0] | (p_in[0] & c0);
    for (int d = 0; d < LOG_W; d++) begin
      for (int i = 0; i < WORD_W; i++) begin
        if (((i + 1) % (2 << d)) == 0) begin
          g[i] = g[i] | (p[i] & g[i - (1 << d)]);
          p[i] = p[i] & p[i - (1 << d)];
        end else begin
          g[i] = g[i];
        end
      end
    end
    for (int d = LOG_W - 2; d >= 0; d--) begin
      for (int i = 0; i < WORD_W; i++) begin
        if ((((i + 1) % (2 << d)) == (1 << d)) && (i > (1 << d))) begin
          g[i] = g[i] | (p[i] & g[i - (1 << d)]);
        end else begin
          g[i] = g[i];
        end
      end
    end
    return g;
  endfunction

  // Bitwise generate/propagate, prefix carries, then the sum bits.
  always_comb begin
    g_s     = a & b;
    p_s     = a ^ b;
    carry_s = bk_carries(g_s, p_s, ci);
    s       = p_s ^ {carry_s[WORD_W-2:0], ci};
    co      = carry_s[WORD_W-1];
  end

endmodule

// File: rtl/bk_multiword_add_seq.sv
// Multi-word add/subtract sequencer: one shared 32-bit Brent-Kung adder is
// stepped over NWORDS words, least significant first, with the carry chained
// through a register. Operands are captured on accept; the result is held
// stable in DONE until the sink takes it.
module bk_multiword_add_seq
  import bk_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  bk_multiword_add_seq_if.slave  bus
);

  localparam int W     = WORD_W * NWORDS;
  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  bk_seq_state_t state_r;
  bk_seq_state_t state_s;

  logic [NWORDS-1:0][WORD_W-1:0] a_r;
  logic [NWORDS-1:0][WORD_W-1:0] b_r;
  logic [NWORDS-1:0][WORD_W-1:0] sum_r;
  logic [IDX_W-1:0]              idx_r;
  logic                          carry_r;
  logic                          zacc_r;
  logic                          cout_r;
  logic                          ovf_r;
  logic                          zero_r;

  logic                          accept_s;
  logic                          step_s;
  logic                          last_s;
  logic [WORD_W-1:0]             s_s;
  logic                          co_s;
  logic                          a_msb_s;
  logic                          b_msb_s;

  // Single shared adder; every input comes from registers.
  brent_kung_adder u_adder (
    .a  (a_r[idx_r]),
    .b  (b_r[idx_r]),
    .ci (carry_r),
    .s  (s_s),
    .co (co_s)
  );

  assign a_msb_s = a_r[NWORDS-1][WORD_W-1];
  assign b_msb_s = b_r[NWORDS-1][WORD_W-1];

  // Next-state and per-cycle control decode.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    step_s   = 1'b0;
    last_s   = (idx_r == LAST_IDX);
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, word-serial accumulation and result/flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      zacc_r  <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
    end else if (accept_s) begin
      // Subtraction is A + ~B + 1: invert B here and force the first carry.
      a_r     <= bus.op_a;
      b_r     <= bus.op_b ^ {W{bus.sub}};
      carry_r <= bus.sub | bus.cin;
      idx_r   <= '0;
      zacc_r  <= 1'b1;
    end else if (step_s) begin
      sum_r[idx_r] <= s_s;
      carry_r      <= co_s;
      zacc_r       <= zacc_r & (s_s == '0);
      if (last_s) begin
        idx_r  <= '0;
        cout_r <= co_s;
        ovf_r  <= (a_msb_s == b_msb_s) && (s_s[WORD_W-1] != a_msb_s);
        zero_r <= zacc_r & (s_s == '0);
      end else begin
        idx_r  <= idx_r + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == DONE);
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;

endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// Scoreboard bench for bk_multiword_add_seq with NWORDS=4: the driver pushes
// expected results (plain wide arithmetic) at accept; a negedge monitor pops
// and compares on every out_valid && out_ready.
module tb_bk_multiword_add_seq;

  localparam int NW = 4;
  localparam int W  = 32 * NW;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb[$];
  int   checks;
  int   errors;

  bk_multiword_add_seq_if #(.NWORDS(NW)) bus ();

  bk_multiword_add_seq #(.NWORDS(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic c);
    logic [W-1:0] be;
    logic [W:0]   full;
    exp_t         e;
    be     = s ? ~b : b;
    full   = {1'b0, a} + {1'b0, be} + (W+1)'(s | c);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == be[W-1]) && (e.sum[W-1] != a[W-1]);
    e.zero = (e.sum == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every consumed result is compared against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum %h with no pending request", bus.sum);
      end else begin
        e = sb.pop_front();
        chk("sum",  bus.sum, e.sum);
        chk("cout", W'(bus.cout), W'(e.cout));
        chk("ovf",  W'(bus.ovf),  W'(e.ovf));
        chk("zero", W'(bus.zero), W'(e.zero));
      end
    end
  end

  // Presents a request and returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic c, input bit use_exp, input exp_t ex, input bit push);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", W'(bus.in_ready), W'(1));
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = s;
    bus.cin      = c;
    @(posedge clk); #1;
    if (push) sb.push_back(use_exp ? ex : model(a, b, s, c));
    bus.in_valid = 1'b0;
    bus.op_a     = rnd_w();
    bus.op_b     = rnd_w();
    bus.sub      = 1'($urandom_range(0, 1));
    bus.cin      = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", W'(n), W'(NW));
  endtask

  // Full operation with an optional sink stall of 'stall' cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic c, input bit use_exp, input exp_t ex, input int stall);
    logic [W-1:0] held;
    bus.out_ready = (stall == 0);
    issue(a, b, s, c, use_exp, ex, 1'b1);
    wait_result();
    held = bus.sum;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      chk("stall_sum", bus.sum, held);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_to_idle", W'(bus.in_ready), W'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t         e;
    exp_t         none;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] held;
    int           mode;
    checks = 0;
    errors = 0;
    none   = '0;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.sub       = 1'b0;
    bus.cin       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  W'(bus.in_ready),  W'(1));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_sum",       bus.sum,           '0);
    chk("rst_cout",      W'(bus.cout),      W'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Carry ripples across three full words into the top word.
    e.sum = 128'h0000_0001_0000_0000_0000_0000_0000_0000; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0;
    run_op(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0, 1'b1, e, 0);

    // All ones + 0 + cin wraps to zero.
    e.sum = '0; e.cout = 1'b1; e.ovf = 1'b0; e.zero = 1'b1;
    run_op({W{1'b1}}, 128'd0, 1'b0, 1'b1, 1'b1, e, 0);

    // 5 - 7 borrows out.
    e.sum = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE; e.cout = 1'b0; e.ovf = 1'b0; e.zero = 1'b0;
    run_op(128'd5, 128'd7, 1'b1, 1'b0, 1'b1, e, 0);

    // Max positive + 1 overflows.
    e.sum = 128'h8000_0000_0000_0000_0000_0000_0000_0000; e.cout = 1'b0; e.ovf = 1'b1; e.zero = 1'b0;
    run_op(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0, 1'b1, e, 0);

    // Reset mid-RUN discards the operation; outputs return to reset values.
    issue(rnd_w(), rnd_w(), 1'b0, 1'b1, 1'b0, none, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrun_in_ready",  W'(bus.in_ready),  W'(1));
    chk("midrun_out_valid", W'(bus.out_valid), W'(0));
    chk("midrun_sum",       bus.sum,           '0);
    chk("midrun_cout",      W'(bus.cout),      W'(0));
    repeat (NW + 2) @(posedge clk);
    #1;
    chk("midrun_no_pulse", W'(bus.out_valid), W'(0));

    // Backpressure in DONE with a new request waiting.
    bus.out_ready = 1'b0;
    a = rnd_w();
    b = rnd_w();
    issue(a, b, 1'b0, 1'b0, 1'b0, none, 1'b1);
    wait_result();
    held         = bus.sum;
    a            = rnd_w();
    b            = rnd_w();
    bus.in_valid = 1'b1;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.sub      = 1'b1;
    bus.cin      = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_sum",       bus.sum,           held);
      chk("bp_in_ready",  W'(bus.in_ready),  W'(0));
      chk("bp_out_valid", W'(bus.out_valid), W'(1));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle",  W'(bus.in_ready),  W'(1));
    chk("bp_release_valid", W'(bus.out_valid), W'(0));
    chk("bp_retain_sum",    bus.sum,           held);
    @(posedge clk); #1;
    sb.push_back(model(a, b, 1'b1, 1'b0));
    chk("bp_second_accept", W'(bus.in_ready), W'(0));
    bus.in_valid = 1'b0;
    wait_result();
    @(posedge clk); #1;

    // Randomized operations with occasional edge-case operand shapes and stalls.
    for (int t = 0; t < 30; t++) begin
      mode = int'($urandom_range(0, 3));
      a    = rnd_w();
      case (mode)
        0: b = rnd_w();
        1: b = ~a;
        2: b = a;
        default: b = {96'd0, 32'($urandom)};
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, none,
             int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", W'(sb.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
